condicionador_entrada: RTL and testbench



---
 rtl/condicionador_entrada.sv | 117 +++++++++++
 tb/tb_condicionador_entrada.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/condicionador_entrada.sv
// Input conditioner: synchronises the pushbutton and digit switches, debounces the
// button on both edges and emits one insere/invalido pulse per clean press.
//
// state       | meaning
// SOLTO       | button released and stable
// CONF_PRESS  | button seen high, confirming the press
// PRESSIONADO | press accepted, button held
// CONF_SOLTO  | button seen low, confirming the release
module condicionador_entrada #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       botao,
    input  logic [4:1] chaves,
    output logic       insere,
    output logic [4:1] numero,
    output logic       invalido,
    output logic       ocupado
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] SOLTO       = 2'd0;
    localparam logic [1:0] CONF_PRESS  = 2'd1;
    localparam logic [1:0] PRESSIONADO = 2'd2;
    localparam logic [1:0] CONF_SOLTO  = 2'd3;

    logic          botao_m, botao_s;
    logic [4:1]    chaves_m, chaves_s;
    logic [1:0]    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          aceita;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            botao_m  <= 1'b0;
            botao_s  <= 1'b0;
            chaves_m <= 4'b0000;
            chaves_s <= 4'b0000;
        end else begin
            botao_m  <= botao;
            botao_s  <= botao_m;
            chaves_m <= chaves;
            chaves_s <= chaves_m;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        aceita    = 1'b0;
        case (state)
            SOLTO: begin
                if (botao_s) begin
                    state_nxt = CONF_PRESS;
                    cnt_nxt   = '0;
                end
            end
            CONF_PRESS: begin
                if (!botao_s) begin
                    state_nxt = SOLTO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = PRESSIONADO;
                    cnt_nxt   = '0;
                    aceita    = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            PRESSIONADO: begin
                if (!botao_s) begin
                    state_nxt = CONF_SOLTO;
                    cnt_nxt   = '0;
                end
            end
            CONF_SOLTO: begin
                // a high sample here is release bounce, not a new press
                if (botao_s) begin
                    state_nxt = PRESSIONADO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = SOLTO;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = SOLTO;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= SOLTO;
            cnt      <= '0;
            insere   <= 1'b0;
            invalido <= 1'b0;
            numero   <= 4'b0000;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            insere   <= aceita && (chaves_s <= 4'd9);
            invalido <= aceita && (chaves_s > 4'd9);
            if (aceita && (chaves_s <= 4'd9))
                numero <= chaves_s;
        end
    end

    assign ocupado = (state == PRESSIONADO) || (state == CONF_SOLTO);

endmodule

// File: tb/tb_condicionador_entrada.sv
// Bench for condicionador_entrada: drives button/switch patterns and compares every
// cycle against a sample-history model of the debounce rules.
module tb_condicionador_entrada;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       botao;
    logic [4:1] chaves;
    logic       insere, invalido, ocupado;
    logic [4:1] numero;

    int n_cmp = 0;
    int n_err = 0;

    condicionador_entrada #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .botao    (botao),
        .chaves   (chaves),
        .insere   (insere),
        .numero   (numero),
        .invalido (invalido),
        .ocupado  (ocupado)
    );

    always #5 clk = ~clk;

    // model: raw samples reach the debouncer two edges late; a press is accepted once
    // D+1 consecutive high samples are seen while released, and released after D+1 lows
    bit         bq[$];
    logic [3:0] cq[$];
    bit         m_held, m_ins, m_inv;
    int         run1, run0;
    logic [3:0] m_num;

    task automatic model_reset();
        bq.delete(); cq.delete();
        bq.push_back(1'b0); bq.push_back(1'b0);
        cq.push_back(4'd0); cq.push_back(4'd0);
        m_held = 0; m_ins = 0; m_inv = 0;
        run1 = 0; run0 = 0;
        m_num = 4'd0;
    endtask

    task automatic model_step(input bit b, input logic [3:0] c);
        bit         bs;
        logic [3:0] cs;
        bs = bq.pop_front();
        cs = cq.pop_front();
        bq.push_back(b);
        cq.push_back(c);
        m_ins = 0; m_inv = 0;
        if (bs) begin run1++; run0 = 0; end
        else    begin run0++; run1 = 0; end
        if (!m_held && run1 == D + 1) begin
            m_held = 1;
            if (cs <= 9) begin m_num = cs; m_ins = 1; end
            else m_inv = 1;
        end else if (m_held && run0 == D + 1) begin
            m_held = 0;
        end
    endtask

    // called at a falling edge; returns at the next falling edge
    task automatic tick(input bit b, input logic [3:0] c);
        botao  = b;
        chaves = c;
        @(posedge clk);
        if (reset) model_reset();
        else model_step(b, c);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; botao = 1'b1; chaves = 4'd7;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 4'd7);
            n_cmp++;
            if ({insere, invalido, ocupado, numero} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, {insere, invalido, ocupado, numero}, 7'b0);
            end
        end
        botao = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick(1'b0, 4'd0);
    endtask

    task automatic test_clean_press();
        int pulses, pulse_at, fall_at;
        pulses = 0; pulse_at = 0; fall_at = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1'b1, 4'd5);
            n_cmp++;
            if ({insere, invalido, ocupado, numero} !== {m_ins, m_inv, m_held, m_num}) begin
                n_err++;
                $display("FAIL clean_press cyc=%0d got=%b want=%b", i, {insere, invalido, ocupado, numero}, {m_ins, m_inv, m_held, m_num});
            end
            if (insere) begin pulses++; if (pulse_at == 0) pulse_at = i; end
        end
        n_cmp++;
        if (pulses != 1 || pulse_at != 7) begin
            n_err++;
            $display("FAIL clean_press_pulse got count=%0d at=%0d want count=1 at=7", pulses, pulse_at);
        end
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 4'd5);
            n_cmp++;
            if ({insere, invalido, ocupado, numero} !== {m_ins, m_inv, m_held, m_num}) begin
                n_err++;
                $display("FAIL clean_release cyc=%0d got=%b want=%b", i, {insere, invalido, ocupado, numero}, {m_ins, m_inv, m_held, m_num});
            end
            if (!ocupado && fall_at == 0) fall_at = i;
        end
        n_cmp++;
        if (fall_at != 7) begin
            n_err++;
            $display("FAIL ocupado_fall got=%0d want=7", fall_at);
        end
    endtask

    task automatic test_bouncy_press();
        bit pat[20];
        int pulses, pulse_at;
        pulses = 0; pulse_at = 0;
        for (int i = 0; i < 20; i++) pat[i] = 1'b1;
        pat[2] = 1'b0; pat[4] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick(pat[i-1], 4'd3);
            n_cmp++;
            if ({insere, invalido, ocupado, numero} !== {m_ins, m_inv, m_held, m_num}) begin
                n_err++;
                $display("FAIL bouncy_press cyc=%0d got=%b want=%b", i, {insere, invalido, ocupado, numero}, {m_ins, m_inv, m_held, m_num});
            end
            if (insere) begin pulses++; if (pulse_at == 0) pulse_at = i; end
        end
        n_cmp++;
        if (pulses != 1 || pulse_at != 12) begin
            n_err++;
            $display("FAIL bouncy_pulse got count=%0d at=%0d want count=1 at=12", pulses, pulse_at);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 4'd3);
    endtask

    task automatic test_invalid_digit();
        int ins_n, inv_n;
        bit busy_seen;
        ins_n = 0; inv_n = 0; busy_seen = 0;
        for (int i = 0; i < 10; i++) tick(1'b1, 4'd5);
        for (int i = 0; i < 10; i++) tick(1'b0, 4'd5);
        for (int i = 1; i <= 20; i++) begin
            tick(i <= 10, 4'b1100);
            n_cmp++;
            if ({insere, invalido, ocupado, numero} !== {m_ins, m_inv, m_held, m_num}) begin
                n_err++;
                $display("FAIL invalid_digit cyc=%0d got=%b want=%b", i, {insere, invalido, ocupado, numero}, {m_ins, m_inv, m_held, m_num});
            end
            ins_n += int'(insere);
            inv_n += int'(invalido);
            if (ocupado) busy_seen = 1;
        end
        n_cmp++;
        if (ins_n != 0 || inv_n != 1 || numero !== 4'd5 || !busy_seen) begin
            n_err++;
            $display("FAIL invalid_summary got ins=%0d inv=%0d num=%0d busy=%0d want ins=0 inv=1 num=5 busy=1", ins_n, inv_n, numero, busy_seen);
        end
    endtask

    task automatic test_release_bounce();
        int pulses;
        pulses = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(i <= 10 || (i > 12 && i <= 20), 4'd7);
            n_cmp++;
            if ({insere, invalido, ocupado, numero} !== {m_ins, m_inv, m_held, m_num}) begin
                n_err++;
                $display("FAIL release_bounce cyc=%0d got=%b want=%b", i, {insere, invalido, ocupado, numero}, {m_ins, m_inv, m_held, m_num});
            end
            pulses += int'(insere);
            if (i >= 7 && i <= 22 && ocupado !== 1'b1) begin
                n_err++;
                $display("FAIL release_bounce_busy cyc=%0d got=%b want=1", i, ocupado);
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_err++;
            $display("FAIL release_bounce_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] digits[6];
        int pulses;
        digits = '{4'd5, 4'd9, 4'd0, 4'd9, 4'd8, 4'd1};
        pulses = 0;
        foreach (digits[k]) begin
            for (int i = 1; i <= 16; i++) begin
                // switches only need to be right up to the sample feeding the acceptance edge
                tick(i <= 8, (i <= 5) ? digits[k] : 4'($urandom_range(0, 15)));
                n_cmp++;
                if ({insere, invalido, ocupado, numero} !== {m_ins, m_inv, m_held, m_num}) begin
                    n_err++;
                    $display("FAIL back_to_back d=%0d cyc=%0d got=%b want=%b", k, i, {insere, invalido, ocupado, numero}, {m_ins, m_inv, m_held, m_num});
                end
                if (insere) begin
                    pulses++;
                    if (numero !== digits[k]) begin
                        n_err++;
                        $display("FAIL back_to_back_num d=%0d got=%0d want=%0d", k, numero, digits[k]);
                    end
                end
            end
        end
        n_cmp++;
        if (pulses != 6) begin
            n_err++;
            $display("FAIL back_to_back_pulses got=%0d want=6", pulses);
        end
    endtask

    task automatic test_async_reset_held();
        int pulses, pulse_at;
        pulses = 0; pulse_at = 0;
        for (int i = 0; i < 10; i++) tick(1'b1, 4'd9);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({insere, invalido, ocupado, numero} !== 7'b0) begin
            n_err++;
            $display("FAIL async_reset_now got=%b want=%b", {insere, invalido, ocupado, numero}, 7'b0);
        end
        model_reset();
        @(negedge clk);
        tick(1'b1, 4'd9);
        tick(1'b1, 4'd9);
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 4'd9);
            n_cmp++;
            if ({insere, invalido, ocupado, numero} !== {m_ins, m_inv, m_held, m_num}) begin
                n_err++;
                $display("FAIL reset_held_press cyc=%0d got=%b want=%b", i, {insere, invalido, ocupado, numero}, {m_ins, m_inv, m_held, m_num});
            end
            if (insere) begin pulses++; if (pulse_at == 0) pulse_at = i; end
        end
        n_cmp++;
        if (pulses != 1 || pulse_at != 7 || numero !== 4'd9) begin
            n_err++;
            $display("FAIL reset_held_pulse got count=%0d at=%0d num=%0d want count=1 at=7 num=9", pulses, pulse_at, numero);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 4'd9);
    endtask

    task automatic test_reset_mid_debounce();
        int pulses, pulse_at;
        pulses = 0; pulse_at = 0;
        for (int i = 0; i < 5; i++) tick(1'b1, 4'd6);
        #2 reset = 1'b1;
        model_reset();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if ({insere, invalido, ocupado, numero} !== 7'b0) begin
                n_err++;
                $display("FAIL reset_mid_hold cyc=%0d got=%b want=%b", i, {insere, invalido, ocupado, numero}, 7'b0);
            end
        end
        @(negedge clk);
        model_reset();
        reset = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b1, 4'd6);
            n_cmp++;
            if ({insere, invalido, ocupado, numero} !== {m_ins, m_inv, m_held, m_num}) begin
                n_err++;
                $display("FAIL reset_mid_press cyc=%0d got=%b want=%b", i, {insere, invalido, ocupado, numero}, {m_ins, m_inv, m_held, m_num});
            end
            if (insere) begin pulses++; if (pulse_at == 0) pulse_at = i; end
        end
        n_cmp++;
        if (pulses != 1 || pulse_at != 7) begin
            n_err++;
            $display("FAIL reset_mid_pulse got count=%0d at=%0d want count=1 at=7", pulses, pulse_at);
        end
        for (int i = 0; i < 10; i++) tick(1'b0, 4'd6);
    endtask

    task automatic test_random();
        bit lvl;
        int left;
        lvl = 1'b0; left = 0;
        for (int i = 1; i <= 400; i++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = $urandom_range(1, 9);
            end
            left--;
            tick(lvl, 4'($urandom_range(0, 15)));
            n_cmp++;
            if ({insere, invalido, ocupado, numero} !== {m_ins, m_inv, m_held, m_num}) begin
                n_err++;
                $display("FAIL random cyc=%0d got=%b want=%b", i, {insere, invalido, ocupado, numero}, {m_ins, m_inv, m_held, m_num});
            end
        end
        for (int i = 0; i < 12; i++) tick(1'b0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bouncy_press();
        test_invalid_digit();
        test_release_bounce();
        test_back_to_back();
        test_async_reset_held();
        test_reset_mid_debounce();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
